aes_inv_sub_bytes_seq: RTL
==========================

Name: aes_inv_sub_bytes_seq

Overview:
- Iterative AES InvSubBytes engine for the decryption datapath: the inverse of the forward byte substitution.
- Accepts a 128-bit state over a valid/ready handshake and applies the FIPS-197 inverse S-box to all 16 bytes, LANES bytes per cycle.
- Returns the result over a second valid/ready handshake.
- Sits between InvShiftRows and AddRoundKey in the inverse cipher round loop.

Parameters:
- LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is a fatal elaboration error.
- NSTEPS, 16/LANES, derived (localparam), number of RUN cycles per block.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input state presented.
- in_ready  out  1  block can accept a state.
- in_state  in  128  ciphertext-side state; byte i = in_state[127-8i -: 8], byte 0 at the MSB.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_state  out  128  substituted state, same byte mapping.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): FSM goes to IDLE, work register = 0, step counter = 0. out_valid=0, out_state=0, busy=0, in_ready=0 while rst is high.
- Reset applied mid-operation discards the block; no partial output is ever presented.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: capture in_state into the work register, cnt=0, go to RUN.
- RUN:
  - in_ready=0.
  - Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of the work register are replaced in place by inv_sbox(byte), then cnt increments.
  - When cnt==NSTEPS-1 that cycle's update completes, go to DONE.
- DONE:
  - out_valid=1; out_state = work register, held stable until the handshake completes.
  - On out_ready: out_valid drops the next cycle, go to IDLE.
  - in_valid is ignored in DONE (in_ready=0).
- Latency: acceptance edge to out_valid high = NSTEPS cycles (4 for LANES=4, 1 for LANES=16).
- Throughput: one block per NSTEPS+2 cycles when out_ready is held high.
- out_state is registered: it equals the work register only in DONE and is 0 otherwise.
- The cnt width is $clog2(NSTEPS) with a minimum of 1 bit. cnt wraps to 0 on the DONE→IDLE transition and is never compared beyond NSTEPS-1.
- in_state changing while the block is not in IDLE has no effect.
- The inverse S-box is a purely combinational 256-entry table, exact per FIPS-197 Fig. 14; no undefined outputs.

Decomposition:
- aes_pkg holds:
  - AES_STATE_W=128 and AES_NBYTES=16.
  - typedef aes_byte_t (logic [7:0]).
  - typedef enum inv_sb_state_t {IDLE, RUN, DONE}.
- Sub-module inv_sbox (din[7:0] → dout[7:0], combinational case table). It is instantiated LANES times.
- Lane k's byte select is a mux over cnt; it is not a shift register, so byte order is preserved.

Test Plan:
1. FIPS-197 Appendix B, round 1:
   - Stimulus: in_state=d42711aee0bf98f1b8b45de51e415230, out_ready=1.
   - Required: out_state=193de3bea0f4e22b9ac68d2ae9f84808, and out_valid rises exactly 4 cycles after acceptance (LANES=4).
2. Point values:
   - Stimulus: in_state with bytes 63,7c,16,00,52,ed,… (remaining bytes 63).
   - Required: leading bytes 00,01,ff,52,48,53, remaining bytes 00.
   - Repeat with LANES=1 (16-cycle latency) and LANES=16 (1-cycle latency); results must be identical.
3. Backpressure:
   - Stimulus: hold out_ready=0 for 10 cycles in DONE, and drive a new in_valid with random in_state during that time.
   - Required: out_state stable, out_valid high, in_ready=0, new input not captured.
   - Then raise out_ready: out_valid falls next cycle and in_ready=1.
4. Reset mid-RUN:
   - Stimulus: assert rst at cnt=2 for one cycle.
   - Required: next cycle FSM in IDLE, out_valid=0, out_state=0, in_ready=1 after rst drops, and no output ever appears for the aborted block.
5. Round-trip:
   - Stimulus: 1000 random states, each passed bytewise through a bench instance of the forward sbox, then this block, with random valid/ready gaps.
   - Required: every output equals the original state, in order, with no drops or duplicates.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions for the inverse byte-substitution engine.
//   AES_STATE_W / AES_NBYTES : state width in bits / bytes
//   aes_byte_t               : one state byte
//   inv_sb_state_t           : control FSM states of aes_inv_sub_bytes_seq
package aes_pkg;

  localparam int unsigned AES_STATE_W = 128;
  localparam int unsigned AES_NBYTES  = 16;

  typedef logic [7:0] aes_byte_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } inv_sb_state_t;

endpackage

// File: rtl/inv_sbox.sv
// AES inverse S-box: purely combinational 256-entry lookup.
//   din  : input byte
//   dout : inverse-substituted byte
module inv_sbox
  import aes_pkg::*;
(
  input  aes_byte_t din,
  output aes_byte_t dout
);

  always_comb begin
    dout = '0;
    unique case (din)
      8'h00: dout = 8'h52; 8'h01: dout = 8'h09; 8'h02: dout = 8'h6a; 8'h03: dout = 8'hd5;
      8'h04: dout = 8'h30; 8'h05: dout = 8'h36; 8'h06: dout = 8'ha5; 8'h07: dout = 8'h38;
      8'h08: dout = 8'hbf; 8'h09: dout = 8'h40; 8'h0a: dout = 8'ha3; 8'h0b: dout = 8'h9e;
      8'h0c: dout = 8'h81; 8'h0d: dout = 8'hf3; 8'h0e: dout = 8'hd7; 8'h0f: dout = 8'hfb;
      8'h10: dout = 8'h7c; 8'h11: dout = 8'he3; 8'h12: dout = 8'h39; 8'h13: dout = 8'h82;
      8'h14: dout = 8'h9b; 8'h15: dout = 8'h2f; 8'h16: dout = 8'hff; 8'h17: dout = 8'h87;
      8'h18: dout = 8'h34; 8'h19: dout = 8'h8e; 8'h1a: dout = 8'h43; 8'h1b: dout = 8'h44;
      8'h1c: dout = 8'hc4; 8'h1d: dout = 8'hde; 8'h1e: dout = 8'he9; 8'h1f: dout = 8'hcb;
      8'h20: dout = 8'h54; 8'h21: dout = 8'h7b; 8'h22: dout = 8'h94; 8'h23: dout = 8'h32;
      8'h24: dout = 8'ha6; 8'h25: dout = 8'hc2; 8'h26: dout = 8'h23; 8'h27: dout = 8'h3d;
      8'h28: dout = 8'hee; 8'h29: dout = 8'h4c; 8'h2a: dout = 8'h95; 8'h2b: dout = 8'h0b;
      8'h2c: dout = 8'h42; 8'h2d: dout = 8'hfa; 8'h2e: dout = 8'hc3; 8'h2f: dout = 8'h4e;
      8'h30: dout = 8'h08; 8'h31: dout = 8'h2e; 8'h32: dout = 8'ha1; 8'h33: dout = 8'h66;
      8'h34: dout = 8'h28; 8'h35: dout = 8'hd9; 8'h36: dout = 8'h24; 8'h37: dout = 8'hb2;
      8'h38: dout = 8'h76; 8'h39: dout = 8'h5b; 8'h3a: dout = 8'ha2; 8'h3b: dout = 8'h49;
      8'h3c: dout = 8'h6d; 8'h3d: dout = 8'h8b; 8'h3e: dout = 8'hd1; 8'h3f: dout = 8'h25;
      8'h40: dout = 8'h72; 8'h41: dout = 8'hf8; 8'h42: dout = 8'hf6; 8'h43: dout = 8'h64;
      8'h44: dout = 8'h86; 8'h45: dout = 8'h68; 8'h46: dout = 8'h98; 8'h47: dout = 8'h16;
      8'h48: dout = 8'hd4; 8'h49: dout = 8'ha4; 8'h4a: dout = 8'h5c; 8'h4b: dout = 8'hcc;
      8'h4c: dout = 8'h5d; 8'h4d: dout = 8'h65; 8'h4e: dout = 8'hb6; 8'h4f: dout = 8'h92;
      8'h50: dout = 8'h6c; 8'h51: dout = 8'h70; 8'h52: dout = 8'h48; 8'h53: dout = 8'h50;
      8'h54: dout = 8'hfd; 8'h55: dout = 8'hed; 8'h56: dout = 8'hb9; 8'h57: dout = 8'hda;
      8'h58: dout = 8'h5e; 8'h59: dout = 8'h15; 8'h5a: dout = 8'h46; 8'h5b: dout = 8'h57;
      8'h5c: dout = 8'ha7; 8'h5d: dout = 8'h8d; 8'h5e: dout = 8'h9d; 8'h5f: dout = 8'h84;
      8'h60: dout = 8'h90; 8'h61: dout = 8'hd8; 8'h62: dout = 8'hab; 8'h63: dout = 8'h00;
      8'h64: dout = 8'h8c; 8'h65: dout = 8'hbc; 8'h66: dout = 8'hd3; 8'h67: dout = 8'h0a;
      8'h68: dout = 8'hf7; 8'h69: dout = 8'he4; 8'h6a: dout = 8'h58; 8'h6b: dout = 8'h05;
      8'h6c: dout = 8'hb8; 8'h6d: dout = 8'hb3; 8'h6e: dout = 8'h45; 8'h6f: dout = 8'h06;
      8'h70: dout = 8'hd0; 8'h71: dout = 8'h2c; 8'h72: dout = 8'h1e; 8'h73: dout = 8'h8f;
      8'h74: dout = 8'hca; 8'h75: dout = 8'h3f; 8'h76: dout = 8'h0f; 8'h77: dout = 8'h02;
      8'h78: dout = 8'hc1; 8'h79: dout = 8'haf; 8'h7a: dout = 8'hbd; 8'h7b: dout = 8'h03;
      8'h7c: dout = 8'h01; 8'h7d: dout = 8'h13; 8'h7e: dout = 8'h8a; 8'h7f: dout = 8'h6b;
      8'h80: dout = 8'h3a; 8'h81: dout = 8'h91; 8'h82: dout = 8'h11; 8'h83: dout = 8'h41;
      8'h84: dout = 8'h4f; 8'h85: dout = 8'h67; 8'h86: dout = 8'hdc; 8'h87: dout = 8'hea;
      8'h88: dout = 8'h97; 8'h89: dout = 8'hf2; 8'h8a: dout = 8'hcf; 8'h8b: dout = 8'hce;
      8'h8c: dout = 8'hf0; 8'h8d: dout = 8'hb4; 8'h8e: dout = 8'he6; 8'h8f: dout = 8'h73;
      8'h90: dout = 8'h96; 8'h91: dout = 8'hac; 8'h92: dout = 8'h74; 8'h93: dout = 8'h22;
      8'h94: dout = 8'he7; 8'h95: dout = 8'had; 8'h96: dout = 8'h35; 8'h97: dout = 8'h85;
      8'h98: dout = 8'he2; 8'h99: dout = 8'hf9; 8'h9a: dout = 8'h37; 8'h9b: dout = 8'he8;
      8'h9c: dout = 8'h1c; 8'h9d: dout = 8'h75; 8'h9e: dout = 8'hdf; 8'h9f: dout = 8'h6e;
      8'ha0: dout = 8'h47; 8'ha1: dout = 8'hf1; 8'ha2: dout = 8'h1a; 8'ha3: dout = 8'h71;
      8'ha4: dout = 8'h1d; 8'ha5: dout = 8'h29; 8'ha6: dout = 8'hc5; 8'ha7: dout = 8'h89;
      8'ha8: dout = 8'h6f; 8'ha9: dout = 8'hb7; 8'haa: dout = 8'h62; 8'hab: dout = 8'h0e;
      8'hac: dout = 8'haa; 8'had: dout = 8'h18; 8'hae: dout = 8'hbe; 8'haf: dout = 8'h1b;
      8'hb0: dout = 8'hfc; 8'hb1: dout = 8'h56; 8'hb2: dout = 8'h3e; 8'hb3: dout = 8'h4b;
      8'hb4: dout = 8'hc6; 8'hb5: dout = 8'hd2; 8'hb6: dout = 8'h79; 8'hb7: dout = 8'h20;
      8'hb8: dout = 8'h9a; 8'hb9: dout = 8'hdb; 8'hba: dout = 8'hc0; 8'hbb: dout = 8'hfe;
      8'hbc: dout = 8'h78; 8'hbd: dout = 8'hcd; 8'hbe: dout = 8'h5a; 8'hbf: dout = 8'hf4;
      8'hc0: dout = 8'h1f; 8'hc1: dout = 8'hdd; 8'hc2: dout = 8'ha8; 8'hc3: dout = 8'h33;
      8'hc4: dout = 8'h88; 8'hc5: dout = 8'h07; 8'hc6: dout = 8'hc7; 8'hc7: dout = 8'h31;
      8'hc8: dout = 8'hb1; 8'hc9: dout = 8'h12; 8'hca: dout = 8'h10; 8'hcb: dout = 8'h59;
      8'hcc: dout = 8'h27; 8'hcd: dout = 8'h80; 8'hce: dout = 8'hec; 8'hcf: dout = 8'h5f;
      8'hd0: dout = 8'h60; 8'hd1: dout = 8'h51; 8'hd2: dout = 8'h7f; 8'hd3: dout = 8'ha9;
      8'hd4: dout = 8'h19; 8'hd5: dout = 8'hb5; 8'hd6: dout = 8'h4a; 8'hd7: dout = 8'h0d;
      8'hd8: dout = 8'h2d; 8'hd9: dout = 8'he5; 8'hda: dout = 8'h7a; 8'hdb: dout = 8'h9f;
      8'hdc: dout = 8'h93; 8'hdd: dout = 8'hc9; 8'hde: dout = 8'h9c; 8'hdf: dout = 8'hef;
      8'he0: dout = 8'ha0; 8'he1: dout = 8'he0; 8'he2: dout = 8'h3b; 8'he3: dout = 8'h4d;
      8'he4: dout = 8'hae; 8'he5: dout = 8'h2a; 8'he6: dout = 8'hf5; 8'he7: dout = 8'hb0;
      8'he8: dout = 8'hc8; 8'he9: dout = 8'heb; 8'hea: dout = 8'hbb; 8'heb: dout = 8'h3c;
      8'hec: dout = 8'h83; 8'hed: dout = 8'h53; 8'hee: dout = 8'h99; 8'hef: dout = 8'h61;
      8'hf0: dout = 8'h17; 8'hf1: dout = 8'h2b; 8'hf2: dout = 8'h04; 8'hf3: dout = 8'h7e;
      8'hf4: dout = 8'hba; 8'hf5: dout = 8'h77; 8'hf6: dout = 8'hd6; 8'hf7: dout = 8'h26;
      8'hf8: dout = 8'he1; 8'hf9: dout = 8'h69; 8'hfa: dout = 8'h14; 8'hfb: dout = 8'h63;
      8'hfc: dout = 8'h55; 8'hfd: dout = 8'h21; 8'hfe: dout = 8'h0c; 8'hff: dout = 8'h7d;
    endcase
  end

endmodule

// File: rtl/aes_inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: substitutes LANES bytes of a 128-bit state per cycle.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake, in_state byte i = in_state[127-8i -: 8]
//   out_valid / out_ready: output handshake, out_state uses the same byte mapping
//   busy                 : high while a block is being substituted or waiting to be taken
module aes_inv_sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int unsigned LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_STATE_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_STATE_W-1:0] out_state,
  output logic                   busy
);

  localparam int unsigned NSTEPS = (LANES == 0) ? 1 : AES_NBYTES / LANES;
  localparam int unsigned CNT_W  = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

  if ((LANES != 1) && (LANES != 2) && (LANES != 4) && (LANES != 8) && (LANES != 16))
  begin : g_bad_lanes
    $fatal(1, "aes_inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
  end

  inv_sb_state_t state_q, state_d;
  // Packed [0:15] so byte 0 lands on the MSB, matching the port byte order.
  aes_byte_t [0:AES_NBYTES-1] work_q, work_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] out_state_q, out_state_d;

  logic [3:0] lane_idx [LANES];
  aes_byte_t  sb_out   [LANES];

  // Lane k always works on byte cnt*LANES+k; a mux, not a shifter, so order is kept.
  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      lane_idx[k] = 4'(int'(cnt_q) * LANES + k);
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    inv_sbox u_inv_sbox (
      .din  (work_q[lane_idx[k]]),
      .dout (sb_out[k])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      work_q      <= '0;
      cnt_q       <= '0;
      out_state_q <= '0;
    end else begin
      state_q     <= state_d;
      work_q      <= work_d;
      cnt_q       <= cnt_d;
      out_state_q <= out_state_d;
    end
  end

  // Next-state and datapath
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          work_d  = in_state;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < LANES; k++) begin
          work_d[lane_idx[k]] = sb_out[k];
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(NSTEPS - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          cnt_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // The result register only ever holds a finished block; zero otherwise.
    out_state_d = (state_d == DONE) ? work_d : '0;
  end

  // Outputs
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE: in_ready = 1'b1;
        RUN:  busy = 1'b1;
        DONE: begin
          out_valid = 1'b1;
          busy      = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_state = rst ? '0 : out_state_q;

endmodule
